// File: rtl/spi_slave_responder.sv
// SPI slave responder: oversamples SCK/SS/MOSI in the system clock domain,
// shifts one word per transfer and returns a word from a one-entry tx buffer.
module spi_slave_responder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic        CPOL       = 1'b0,
    parameter logic        CPHA       = 1'b0,
    parameter logic        LSB_FIRST  = 1'b0
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_sck,
    input  logic                  i_ss,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic                  o_miso_oe,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_underrun,
    output logic                  o_busy
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // First received bit ends up at index 0 (LSB first) or at the MSB.
    function automatic logic [DATA_WIDTH-1:0] insert_bit(input logic [DATA_WIDTH-1:0] w,
                                                         input logic b);
        return LSB_FIRST ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
    endfunction

    logic sck_s1_q, sck_s2_q, sck_s3_q, sck_s1_d, sck_s2_d, sck_s3_d;
    logic ss_s1_q, ss_s2_q, ss_s3_q, ss_s1_d, ss_s2_d, ss_s3_d;
    logic mosi_s1_q, mosi_s2_q, mosi_s1_d, mosi_s2_d;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
    logic                    tx_ready_q, tx_ready_d;
    logic                    miso_q, miso_d;
    logic                    miso_oe_q, miso_oe_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    underrun_q, underrun_d;
    logic                    busy_q, busy_d;

    logic                    lead_c, trail_c, ss_fall_c, sample_c, shift_c;
    logic [DATA_WIDTH-1:0]   load_word_c, rx_next_c;

    assign lead_c    = (sck_s2_q != CPOL) && (sck_s3_q == CPOL);
    assign trail_c   = (sck_s2_q == CPOL) && (sck_s3_q != CPOL);
    assign ss_fall_c = !ss_s2_q && ss_s3_q;
    assign sample_c  = CPHA ? trail_c : lead_c;
    // CPHA=0: the trailing edge that follows a word's last sample lands after
    // the reload and must not advance the freshly presented first bit.
    assign shift_c   = CPHA ? lead_c : (trail_c && (bit_cnt_q != '0));
    assign rx_next_c = insert_bit(rx_sh_q, mosi_s2_q);

    always_comb begin
        sck_s1_d    = i_sck;
        sck_s2_d    = sck_s1_q;
        sck_s3_d    = sck_s2_q;
        ss_s1_d     = i_ss;
        ss_s2_d     = ss_s1_q;
        ss_s3_d     = ss_s2_q;
        mosi_s1_d   = i_mosi;
        mosi_s2_d   = mosi_s1_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        tx_buf_d    = tx_buf_q;
        tx_ready_d  = tx_ready_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        busy_d      = !ss_s2_q;
        load_word_c = '0;

        if (i_tx_valid && tx_ready_q) begin
            tx_buf_d   = i_tx_data;
            tx_ready_d = 1'b0;
        end

        if ((state_q != S_IDLE) && ss_s2_q) begin
            state_d   = S_IDLE;
            miso_oe_d = 1'b0;
            miso_d    = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b0;
                    bit_cnt_d = '0;
                    if (ss_fall_c) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!tx_ready_q) begin
                        load_word_c = tx_buf_q;
                        tx_ready_d  = 1'b1;
                    end else begin
                        underrun_d  = 1'b1;
                    end
                    miso_oe_d = 1'b1;
                    bit_cnt_d = '0;
                    rx_sh_d   = '0;
                    miso_d    = CPHA ? 1'b0 : head_bit(load_word_c);
                    tx_sh_d   = CPHA ? load_word_c : advance(load_word_c);
                    state_d   = S_SHIFT;
                end
                S_SHIFT: begin
                    if (shift_c) begin
                        miso_d  = head_bit(tx_sh_q);
                        tx_sh_d = advance(tx_sh_q);
                    end
                    if (sample_c) begin
                        rx_sh_d = rx_next_c;
                        if (bit_cnt_q == LAST_CNT) begin
                            rx_data_d  = rx_next_c;
                            rx_valid_d = 1'b1;
                            bit_cnt_d  = '0;
                            state_d    = S_LOAD;
                        end else begin
                            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            sck_s1_q   <= CPOL;
            sck_s2_q   <= CPOL;
            sck_s3_q   <= CPOL;
            ss_s1_q    <= 1'b1;
            ss_s2_q    <= 1'b1;
            ss_s3_q    <= 1'b1;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            tx_buf_q   <= '0;
            tx_ready_q <= 1'b1;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sck_s1_q   <= sck_s1_d;
            sck_s2_q   <= sck_s2_d;
            sck_s3_q   <= sck_s3_d;
            ss_s1_q    <= ss_s1_d;
            ss_s2_q    <= ss_s2_d;
            ss_s3_q    <= ss_s3_d;
            mosi_s1_q  <= mosi_s1_d;
            mosi_s2_q  <= mosi_s2_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            tx_buf_q   <= tx_buf_d;
            tx_ready_q <= tx_ready_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
        end
    end

    assign o_miso     = miso_q;
    assign o_miso_oe  = miso_oe_q;
    assign o_tx_ready = tx_ready_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_underrun = underrun_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a mode-0 MSB-first instance and a mode-3
// LSB-first instance driven by one behavioural SPI master.
module tb_spi_slave_responder;

    localparam int H = 4;  // SCK half period in system clocks (SCK = clk/8)

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel;                  // 0: mode-0 instance, 1: mode-3 instance
    logic       cpol, cpha, lsb;
    logic       m_sck, m_ss, m_mosi;
    logic [7:0] m_txd;
    logic       m_txv;

    logic sck_a, ss_a, txv_a, sck_b, ss_b, txv_b;
    logic miso_a, oe_a, ready_a, rxv_a, und_a, busy_a;
    logic miso_b, oe_b, ready_b, rxv_b, und_b, busy_b;
    logic [7:0] rxd_a, rxd_b;

    assign sck_a = sel ? 1'b0 : m_sck;
    assign ss_a  = sel ? 1'b1 : m_ss;
    assign txv_a = !sel && m_txv;
    assign sck_b = sel ? m_sck : 1'b1;
    assign ss_b  = sel ? m_ss : 1'b1;
    assign txv_b = sel && m_txv;

    logic       miso_o, oe_o, ready_o, rxv_o, und_o, busy_o;
    logic [7:0] rxd_o;
    assign miso_o  = sel ? miso_b  : miso_a;
    assign oe_o    = sel ? oe_b    : oe_a;
    assign ready_o = sel ? ready_b : ready_a;
    assign rxv_o   = sel ? rxv_b   : rxv_a;
    assign und_o   = sel ? und_b   : und_a;
    assign busy_o  = sel ? busy_b  : busy_a;
    assign rxd_o   = sel ? rxd_b   : rxd_a;

    spi_slave_responder #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) u_dut_m0 (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_sck(sck_a), .i_ss(ss_a), .i_mosi(m_mosi),
        .o_miso(miso_a), .o_miso_oe(oe_a), .i_tx_data(m_txd), .i_tx_valid(txv_a),
        .o_tx_ready(ready_a), .o_rx_data(rxd_a), .o_rx_valid(rxv_a),
        .o_underrun(und_a), .o_busy(busy_a));

    spi_slave_responder #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)) u_dut_m3 (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_sck(sck_b), .i_ss(ss_b), .i_mosi(m_mosi),
        .o_miso(miso_b), .o_miso_oe(oe_b), .i_tx_data(m_txd), .i_tx_valid(txv_b),
        .o_tx_ready(ready_b), .o_rx_data(rxd_b), .o_rx_valid(rxv_b),
        .o_underrun(und_b), .o_busy(busy_b));

    int n_pass  = 0;
    int n_total = 0;
    int nrxv    = 0;
    int nund    = 0;
    logic [7:0] rxq[$];

    // Pulse monitor: counts rx_valid / underrun pulses of the selected instance.
    always @(negedge clk) begin
        if (rxv_o) begin
            nrxv++;
            rxq.push_back(rxd_o);
        end
        if (und_o) nund++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int bidx(input int k);
        return lsb ? k : 7 - k;
    endfunction

    task automatic set_mode(input logic s);
        sel  = s;
        cpol = s;
        cpha = s;
        lsb  = s;
        m_sck = s;
        m_ss  = 1'b1;
        tick(8);
    endtask

    task automatic ss_low();
        m_ss = 1'b0;
        tick(8);
    endtask

    task automatic ss_high();
        m_ss  = 1'b1;
        m_sck = cpol;
        tick(8);
    endtask

    // Master side of one word: drives MOSI from w, captures MISO on the
    // master's sample edge and assembles it in the configured bit order.
    task automatic xfer(input logic [7:0] w, input int nedges, output logic [7:0] got);
        int k;
        got = 8'h00;
        if (!cpha) begin
            m_mosi = w[bidx(0)];
            tick(H);
        end
        for (int e = 0; e < nedges; e++) begin
            k = e / 2;
            if (e % 2 == 0) begin
                m_sck = ~cpol;
                if (cpha) m_mosi = w[bidx(k)];
                else      got[bidx(k)] = miso_o;
            end else begin
                m_sck = cpol;
                if (cpha)       got[bidx(k)] = miso_o;
                else if (k < 7) m_mosi = w[bidx(k + 1)];
            end
            tick(H);
        end
    endtask

    task automatic tx_write(input logic [7:0] w);
        int t = 0;
        while (!ready_o && t < 50) begin
            tick(1);
            t++;
        end
        check("tx_ready_before_write", 32'(ready_o), 32'd1);
        m_txd = w;
        m_txv = 1'b1;
        tick(1);
        m_txv = 1'b0;
    endtask

    logic [7:0] g, g1, g2, t_w, r_w;
    int v0, u0;

    initial begin
        rst = 1'b1; sel = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
        m_sck = 1'b0; m_ss = 1'b1; m_mosi = 1'b0; m_txd = 8'h00; m_txv = 1'b0;
        tick(4);
        check("rst_miso",     32'(miso_a),  32'd0);
        check("rst_miso_oe",  32'(oe_a),    32'd0);
        check("rst_tx_ready", 32'(ready_a), 32'd1);
        check("rst_rx_data",  32'(rxd_a),   32'd0);
        check("rst_rx_valid", 32'(rxv_a),   32'd0);
        check("rst_underrun", 32'(und_a),   32'd0);
        check("rst_busy",     32'(busy_a),  32'd0);
        check("rst_m3_ready", 32'(ready_b), 32'd1);
        rst = 1'b0;
        tick(4);

        // Mode 0: tx 0xA5, master sends 0x3C
        tx_write(8'hA5);
        check("m0_tx_full", 32'(ready_o), 32'd0);
        v0 = nrxv; u0 = nund;
        ss_low();
        check("m0_ready_after_load", 32'(ready_o), 32'd1);
        check("m0_miso_oe",          32'(oe_o),    32'd1);
        check("m0_busy",             32'(busy_o),  32'd1);
        check("m0_no_underrun",      32'(nund - u0), 32'd0);
        xfer(8'h3C, 16, g);
        ss_high();
        check("m0_miso_word", 32'(g),         32'hA5);
        check("m0_rx_data",   32'(rxd_o),     32'h3C);
        check("m0_rx_pulses", 32'(nrxv - v0), 32'd1);
        check("m0_oe_idle",   32'(oe_o),      32'd0);

        // Empty buffer: underrun in LOAD, zeros on MISO
        u0 = nund;
        ss_low();
        check("empty_underrun", 32'(nund - u0), 32'd1);
        xfer(8'hFF, 16, g);
        ss_high();
        check("empty_miso", 32'(g),     32'h00);
        check("empty_rx",   32'(rxd_o), 32'hFF);

        // Back-to-back words with SS held low; a third word covers the reload after word 2
        tx_write(8'h11);
        u0 = nund; rxq.delete();
        ss_low();
        tx_write(8'h22);
        xfer(8'hAA, 16, g1);
        fork
            xfer(8'h55, 16, g2);
            begin
                tick(20);
                tx_write(8'h33);
            end
        join
        ss_high();
        check("b2b_miso_w1",  32'(g1), 32'h11);
        check("b2b_miso_w2",  32'(g2), 32'h22);
        check("b2b_rx_count", 32'(rxq.size()), 32'd2);
        if (rxq.size() == 2) begin
            check("b2b_rx_w1", 32'(rxq[0]), 32'hAA);
            check("b2b_rx_w2", 32'(rxq[1]), 32'h55);
        end
        check("b2b_no_underrun", 32'(nund - u0), 32'd0);

        // Abort after 5 SCK edges of 0xC3
        v0 = nrxv;
        ss_low();
        xfer(8'hC3, 5, g);
        m_ss = 1'b1;
        m_sck = cpol;
        tick(3);
        check("abort_oe_low", 32'(oe_o), 32'd0);
        tick(8);
        check("abort_no_rx_valid", 32'(nrxv - v0), 32'd0);
        check("abort_rx_kept",     32'(rxd_o),     32'h55);
        v0 = nrxv;
        ss_low();
        xfer(8'h5A, 16, g);
        ss_high();
        check("after_abort_rx",    32'(rxd_o),     32'h5A);
        check("after_abort_pulse", 32'(nrxv - v0), 32'd1);

        // Randomized mode-0 words
        for (int i = 0; i < 4; i++) begin
            t_w = 8'($urandom);
            r_w = 8'($urandom);
            tx_write(t_w);
            ss_low();
            xfer(r_w, 16, g);
            ss_high();
            check("rand_m0_miso", 32'(g),     32'(t_w));
            check("rand_m0_rx",   32'(rxd_o), 32'(r_w));
        end

        // Mode 3, LSB first: tx 0x81, master sends 0x01
        set_mode(1'b1);
        tx_write(8'h81);
        v0 = nrxv;
        ss_low();
        xfer(8'h01, 16, g);
        ss_high();
        check("m3_miso_word", 32'(g),         32'h81);
        check("m3_rx_data",   32'(rxd_o),     32'h01);
        check("m3_rx_pulses", 32'(nrxv - v0), 32'd1);
        t_w = 8'($urandom);
        r_w = 8'($urandom);
        tx_write(t_w);
        ss_low();
        xfer(r_w, 16, g);
        ss_high();
        check("rand_m3_miso", 32'(g),     32'(t_w));
        check("rand_m3_rx",   32'(rxd_o), 32'(r_w));

        // Reset mid-word with a full tx buffer
        set_mode(1'b0);
        ss_low();
        tx_write(8'h77);
        check("midrst_buf_full", 32'(ready_o), 32'd0);
        v0 = nrxv;
        xfer(8'h96, 6, g);
        rst = 1'b1;
        tick(1);
        check("midrst_miso",     32'(miso_a),  32'd0);
        check("midrst_miso_oe",  32'(oe_a),    32'd0);
        check("midrst_tx_ready", 32'(ready_a), 32'd1);
        check("midrst_rx_data",  32'(rxd_a),   32'd0);
        check("midrst_rx_valid", 32'(rxv_a),   32'd0);
        check("midrst_underrun", 32'(und_a),   32'd0);
        check("midrst_busy",     32'(busy_a),  32'd0);
        m_ss = 1'b1;
        m_sck = cpol;
        tick(3);
        rst = 1'b0;
        tick(8);
        check("midrst_no_rx_valid", 32'(nrxv - v0), 32'd0);
        u0 = nund;
        ss_low();
        check("postrst_underrun", 32'(nund - u0), 32'd1);
        xfer(8'hFF, 16, g);
        ss_high();
        check("postrst_miso", 32'(g),     32'h00);
        check("postrst_rx",   32'(rxd_o), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
